// File: rtl/baud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : baud_pkg
// Brief    : Baud code type, rate table and elaboration-time divisor helpers
//            shared by the UART baud generator.
// Revision : 1.0
// ============================================================================
package baud_pkg;

    typedef enum logic [2:0] {
        BAUD_4800   = 3'd0,
        BAUD_9600   = 3'd1,
        BAUD_19200  = 3'd2,
        BAUD_38400  = 3'd3,
        BAUD_57600  = 3'd4,
        BAUD_115200 = 3'd5,
        BAUD_RSVD6  = 3'd6,
        BAUD_RSVD7  = 3'd7
    } baud_code_t;

    localparam int unsigned NUM_RATES = 6;
    localparam int unsigned BAUD_TABLE [NUM_RATES] = '{4800, 9600, 19200, 38400, 57600, 115200};

    // round(clk_hz / (baud * os)) using integer arithmetic
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned os,
                                             input int unsigned baud);
        logic [63:0] den;
        logic [63:0] quo;
        den = 64'(baud) * 64'(os);
        quo = (64'(clk_hz) + (den >> 1)) / den;
        return quo[31:0];
    endfunction

    function automatic int unsigned calc_div_w(input int unsigned clk_hz,
                                               input int unsigned os);
        int unsigned max_div;
        max_div = 1;
        for (int i = 0; i < NUM_RATES; i++) begin
            if (calc_div(clk_hz, os, BAUD_TABLE[i]) > max_div) begin
                max_div = calc_div(clk_hz, os, BAUD_TABLE[i]);
            end
        end
        return (max_div < 2) ? 1 : $clog2(max_div);
    endfunction

    // Divider width for the default 50 MHz clock and 16x oversampling
    localparam int unsigned DIV_W = calc_div_w(50_000_000, 16);

    // Reserved codes fall back to 9600
    function automatic baud_code_t sanitize_code(input logic [2:0] code);
        return (code > 3'd5) ? BAUD_9600 : baud_code_t'(code);
    endfunction

endpackage : baud_pkg
`default_nettype wire

// File: rtl/baud_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : baud_mod_counter
// Brief    : Modulo counter with run-time terminal value, clear and a
//            single-cycle wrap pulse.
// Revision : 1.0
// ============================================================================
module baud_mod_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_last;

    // >= rather than == keeps the count bounded if the terminal value shrinks
    assign w_at_last = (r_count >= i_last);
    assign o_wrap    = i_advance && !i_clear && w_at_last;
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_advance) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule : baud_mod_counter
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Selectable-rate UART baud generator producing oversampled rx
//            ticks, bit-rate tx ticks and a tx square wave.
// Revision : 1.0
// ============================================================================
module uart_baud_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_sel,
    output logic       cfg_ready,
    output logic [2:0] active_sel,
    output logic       rx_tick,
    output logic       tx_tick,
    output logic       tx_clk
);

    localparam int unsigned c_DIV_W = calc_div_w(CLK_HZ, OVERSAMPLE);
    localparam int unsigned c_OS_W  = $clog2(OVERSAMPLE);
    localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0] c_OS_HALF = c_OS_W'(OVERSAMPLE / 2 - 1);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_oversample
        $error("uart_baud_gen: OVERSAMPLE must be even and >= 4");
    end
    if (calc_div(CLK_HZ, OVERSAMPLE, 115200) < 2) begin : g_bad_clock
        $error("uart_baud_gen: CLK_HZ too low for the fastest rate");
    end

    // Terminal divider count per code; reserved codes alias to 9600
    logic [c_DIV_W-1:0] w_div_last_tab [8];
    for (genvar gi = 0; gi < 8; gi++) begin : g_div_table
        localparam int unsigned c_IDX = (gi < NUM_RATES) ? gi : 1;
        assign w_div_last_tab[gi] = c_DIV_W'(calc_div(CLK_HZ, OVERSAMPLE, BAUD_TABLE[c_IDX]) - 1);
    end

    baud_code_t         r_active_sel;
    baud_code_t         r_pend_sel;
    logic               r_pend_valid;
    logic               r_tx_clk;
    logic [c_DIV_W-1:0] w_div_last;
    logic [c_DIV_W-1:0] w_div_count_unused;
    logic [c_OS_W-1:0]  w_os_count;
    logic               w_div_wrap;
    logic               w_os_wrap;
    logic               w_accept;
    logic               w_apply;
    logic               w_half;

    assign w_div_last = w_div_last_tab[r_active_sel];

    baud_mod_counter #(
        .WIDTH (c_DIV_W)
    ) u_div_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!enable),
        .i_advance (enable),
        .i_last    (w_div_last),
        .o_count   (w_div_count_unused),
        .o_wrap    (w_div_wrap)
    );

    baud_mod_counter #(
        .WIDTH (c_OS_W)
    ) u_os_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!enable),
        .i_advance (w_div_wrap),
        .i_last    (c_OS_LAST),
        .o_count   (w_os_count),
        .o_wrap    (w_os_wrap)
    );

    assign rx_tick = w_div_wrap;
    assign tx_tick = w_os_wrap;
    assign w_half  = w_div_wrap && (w_os_count == c_OS_HALF);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_tx_clk <= 1'b0;
        end else if (w_half || w_os_wrap) begin
            r_tx_clk <= !r_tx_clk;
        end
    end

    // A pending code commits only at a bit boundary, or immediately while
    // idle; a tx_tick in the accept cycle itself cannot commit it because
    // r_pend_valid is not yet set.
    assign cfg_ready = !r_pend_valid;
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_apply   = r_pend_valid && (!enable || w_os_wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_sel   <= BAUD_9600;
            r_active_sel <= BAUD_9600;
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_sel   <= sanitize_code(cfg_sel);
            if (!enable) begin
                r_active_sel <= sanitize_code(cfg_sel);
            end
        end else if (w_apply) begin
            r_pend_valid <= 1'b0;
            r_active_sel <= r_pend_sel;
        end
    end

    assign active_sel = r_active_sel;
    assign tx_clk     = r_tx_clk;

endmodule : uart_baud_gen
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_baud_gen
// Brief    : Directed, table-driven self-checking bench for uart_baud_gen at
//            50 MHz / 16x oversampling.
// Revision : 1.0
// ============================================================================
module tb_uart_baud_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_sel = 3'd0;
    logic       cfg_ready;
    logic [2:0] active_sel;
    logic       rx_tick;
    logic       tx_tick;
    logic       tx_clk;

    int n_vec  = 0;
    int n_miss = 0;

    uart_baud_gen #(
        .CLK_HZ     (50_000_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_sel    (cfg_sel),
        .cfg_ready  (cfg_ready),
        .active_sel (active_sel),
        .rx_tick    (rx_tick),
        .tx_tick    (tx_tick),
        .tx_clk     (tx_clk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       cv;
        logic [2:0] cs;
        logic       exp_ready;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = 3'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic hit(input int sel);
        case (sel)
            0:       return rx_tick === 1'b1;
            1:       return tx_tick === 1'b1;
            2:       return tx_clk === 1'b1;
            default: return tx_clk === 1'b0;
        endcase
    endfunction

    // Cycle index (1 = current cycle) in which the event is seen; ends at the
    // start of the following cycle. budget+1 means it never came.
    task automatic expect_ev(input string name, input int sel, input int exp);
        bit found;
        int n;
        found = 1'b0;
        n = 6001;
        for (int i = 1; i <= 6000 && !found; i++) begin
            @(negedge clk);
            if (hit(sel)) begin
                n = i;
                found = 1'b1;
            end
            next_cycle();
        end
        chk(name, n, exp);
    endtask

    initial begin
        int bad;
        int n_tx;
        bit found;

        // rst en cv cs  ready sel
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 3'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 3'd5};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd3};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_state", {cfg_ready, active_sel, rx_tick, tx_tick, tx_clk}, {1'b1, 3'd1, 3'b000});
        next_cycle();

        // Handshake / code mapping with enable low
        for (int i = 0; i < 16; i++) begin
            rst       = tbl[i].rst;
            enable    = tbl[i].en;
            cfg_valid = tbl[i].cv;
            cfg_sel   = tbl[i].cs;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {cfg_ready, active_sel, rx_tick, tx_tick, tx_clk},
                {tbl[i].exp_ready, tbl[i].exp_sel, 3'b000});
            next_cycle();
        end

        // Default rate 9600: rx 326, tx 5216, tx_clk 2608/2608
        do_reset();
        enable = 1'b1;
        expect_ev("a_rx_first", 0, 326);
        expect_ev("a_rx_period", 0, 326);
        expect_ev("a_clk_rise", 2, 1957);
        expect_ev("a_clk_high", 3, 2608);
        expect_ev("a_clk_low", 2, 2608);
        expect_ev("a_tx_second", 1, 2607);
        expect_ev("a_tx_period", 1, 5216);

        // Idle request for 115200, then run
        do_reset();
        cfg_valid = 1'b1;
        cfg_sel   = 3'd5;
        next_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("b_sel_idle", active_sel, 3'd5);
        next_cycle();
        enable = 1'b1;
        expect_ev("b_rx_first", 0, 27);
        expect_ev("b_rx_period", 0, 27);
        expect_ev("b_tx_first", 1, 378);
        expect_ev("b_tx_period", 1, 432);

        // Running change 9600 -> 57600 at enabled cycle 1000
        do_reset();
        enable = 1'b1;
        run(999);
        cfg_valid = 1'b1;
        cfg_sel   = 3'd4;
        @(negedge clk);
        chk("c_accept_ready", cfg_ready, 1'b1);
        next_cycle();
        cfg_valid = 1'b0;
        bad = 0;
        found = 1'b0;
        n_tx = 5001;
        for (int i = 1; i <= 5000 && !found; i++) begin
            @(negedge clk);
            if (cfg_ready !== 1'b0 || active_sel !== 3'd1) bad++;
            if (tx_tick === 1'b1) begin
                n_tx = i;
                found = 1'b1;
            end
            next_cycle();
        end
        chk("c_tx_apply", n_tx, 4216);
        chk("c_wait_state", bad, 0);
        @(negedge clk);
        chk("c_applied", {cfg_ready, active_sel}, {1'b1, 3'd4});
        next_cycle();
        expect_ev("c_rx_first", 0, 53);
        expect_ev("c_rx_period", 0, 54);
        // Request landing on a tx_tick waits for the next one
        run(755);
        cfg_valid = 1'b1;
        cfg_sel   = 3'd2;
        @(negedge clk);
        chk("c_tick_accept", {tx_tick, cfg_ready}, 2'b11);
        next_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("c_not_applied", {cfg_ready, active_sel}, {1'b0, 3'd4});
        next_cycle();
        expect_ev("c_tx_next", 1, 863);
        @(negedge clk);
        chk("c_applied2", {cfg_ready, active_sel}, {1'b1, 3'd2});
        next_cycle();
        expect_ev("c_rx_first2", 0, 162);
        expect_ev("c_rx_period2", 0, 163);

        // Reserved code 7 while running
        do_reset();
        enable    = 1'b1;
        cfg_valid = 1'b1;
        cfg_sel   = 3'd7;
        next_cycle();
        cfg_valid = 1'b0;
        expect_ev("d_tx_apply", 1, 5215);
        @(negedge clk);
        chk("d_sel7", {cfg_ready, active_sel}, {1'b1, 3'd1});
        next_cycle();
        expect_ev("d_rx_first", 0, 325);
        expect_ev("d_rx_period", 0, 326);

        // Enable drop at cycle 3000 while tx_clk high
        do_reset();
        enable = 1'b1;
        run(2999);
        enable = 1'b0;
        @(negedge clk);
        chk("e_drop_cycle", {rx_tick, tx_tick, tx_clk}, 3'b001);
        next_cycle();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rx_tick !== 1'b0 || tx_tick !== 1'b0 || tx_clk !== 1'b0) bad++;
            next_cycle();
        end
        chk("e_idle_quiet", bad, 0);
        enable = 1'b1;
        expect_ev("e_rx_reenable", 0, 326);
        expect_ev("e_clk_reenable", 2, 2283);
        // Pending code applied when enable falls
        cfg_valid = 1'b1;
        cfg_sel   = 3'd5;
        @(negedge clk);
        chk("e_accept", cfg_ready, 1'b1);
        next_cycle();
        cfg_valid = 1'b0;
        enable    = 1'b0;
        @(negedge clk);
        chk("e_pending", {cfg_ready, active_sel}, {1'b0, 3'd1});
        next_cycle();
        @(negedge clk);
        chk("e_drop_apply", {cfg_ready, active_sel, tx_clk}, {1'b1, 3'd5, 1'b0});
        next_cycle();
        // Reset mid-run overrides enable and cfg_valid
        enable = 1'b1;
        run(100);
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_sel   = 3'd3;
        next_cycle();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        expect_ev("f_rx_after_rst", 0, 326);
        @(negedge clk);
        chk("f_state_after_rst", {cfg_ready, active_sel}, {1'b1, 3'd1});
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_uart_baud_gen
`default_nettype wire

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter OVERSAMPLE, default 16, rx ticks per bit; SHALL be even and >= 4 (elaboration error otherwise).
REQ-003 clk  input  1  clock; all logic SHALL be on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  run/hold; low holds all counters at 0.
REQ-006 cfg_valid  input  1  request to change baud selection.
REQ-007 cfg_sel  input  3  requested baud code, valid with cfg_valid.
REQ-008 cfg_ready  output  1  high when a new request can be accepted.
REQ-009 active_sel  output  3  baud code currently in use.
REQ-010 rx_tick  output  1  one-cycle pulse at OVERSAMPLE x baud.
REQ-011 tx_tick  output  1  one-cycle pulse at baud (bit boundary).
REQ-012 tx_clk  output  1  square wave at baud, 50% duty in rx_tick units.

Function
REQ-013 Codes SHALL map: 0=4800, 1=9600, 2=19200, 3=38400, 4=57600, 5=115200; codes 6, 7 SHALL map to code 1 (stored active_sel = 1).
REQ-014 Divisor per code SHALL be round(CLK_HZ / (baud x OVERSAMPLE)), computed at elaboration; at defaults: 651, 326, 163, 81, 54, 27.
REQ-015 Divider counter SHALL count 0..DIV-1 while enable high; rx_tick SHALL be high in the cycle the count equals DIV-1, then count wraps to 0.
REQ-016 Oversample counter SHALL advance on each rx_tick, 0..OVERSAMPLE-1; tx_tick SHALL coincide with the rx_tick that wraps it to 0.
REQ-017 tx_clk SHALL be registered and toggle on every (OVERSAMPLE/2)-th rx_tick; first rising edge one cycle after the 8th rx_tick at defaults.
REQ-018 After enable rises from reset/hold state, first rx_tick SHALL occur in the DIV-th enabled cycle; first tx_tick in the (DIV x OVERSAMPLE)-th.
REQ-019 Request accepted when cfg_valid & cfg_ready; accepted code stored as pending, cfg_ready SHALL drop the next cycle.
REQ-020 cfg_valid while cfg_ready low SHALL be ignored; requester holds the request.
REQ-021 With enable high, pending code SHALL be applied at the first tx_tick strictly after the acceptance cycle; new DIV used from the following cycle; cfg_ready high again the cycle after apply.
REQ-022 Request accepted in the same cycle as a tx_tick SHALL wait for the next tx_tick.
REQ-023 With enable low, an accepted request SHALL be applied in the cycle after acceptance.
REQ-024 enable falling SHALL, next cycle: clear both counters, force tx_clk 0, hold rx_tick/tx_tick 0, and apply any pending code.
REQ-025 Divider counter width SHALL be ceil(log2(max DIV)); no overflow permitted for any code.

Reset
REQ-026 On rst: active_sel=1, pending cleared, cfg_ready=1, counters=0, rx_tick=0, tx_tick=0, tx_clk=0.
REQ-027 rst SHALL override enable and cfg_valid in the same cycle; pending request discarded.

Structure
REQ-028 Package baud_pkg SHALL hold the baud code typedef, the rate table, DIV_W constant, and the rounded-divisor function.
REQ-029 Sub-module baud_mod_counter (modulo-N counter with enable, clear, wrap pulse) SHALL be instantiated twice: divider and oversample counters.

Verification
REQ-030 Reset, enable=1, no cfg -> rx_tick every 326 cycles, tx_tick every 5216, tx_clk high 2608 / low 2608.
REQ-031 enable=0, request code 5 -> active_sel=5 next cycle; enable=1 -> rx_tick period 27, tx_tick period 432.
REQ-032 Running at code 1, request code 4 at enabled cycle 1000 -> cfg_ready low until tx_tick at cycle 5216, then rx_tick period 54.
REQ-033 Request code 7 -> active_sel reads 1, rx_tick period 326.
REQ-034 enable low at cycle 3000 -> next cycle tx_clk=0, no ticks; re-enable -> first rx_tick after 326 cycles.
REQ-035 rst asserted while request pending -> cfg_ready=1, active_sel=1, counters 0 next cycle.
